// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state type, nibble
// width and a helper that sizes the nibble index counter.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width: ceil(log2(n)), but never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : nibble_serial_adder_pkg

// File: rtl/nibble_serial_adder_fourbitadder.sv
// Four-bit ripple-carry adder built from a chain of full adders.
module fourbitAdder
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                cout
);

  // carry[0] is the incoming carry; carry[NIBBLE_W] leaves the top bit.
  logic [NIBBLE_W:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carries rippling upward.
  for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_fa
    assign sum[gi]      = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1]  = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[NIBBLE_W];

endmodule : fourbitAdder

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: captures two W-bit operands and a carry, then adds
// them one nibble per cycle through a single four-bit adder, holding the
// registered result until the consumer takes it.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0]  a,
  input  logic [NIBBLE_W*NIBBLES-1:0]  b,
  input  logic                         cin,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0]  sum,
  output logic                         cout,
  output logic                         busy
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = idx_width(NIBBLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

  state_t            state_reg;
  state_t            state_next;
  logic [W-1:0]      a_reg;
  logic [W-1:0]      b_reg;
  logic [W-1:0]      sum_reg;
  logic [W-1:0]      sum_next;
  logic              cout_reg;
  logic              carry_reg;
  logic [IDX_W-1:0]  idx_reg;

  logic [NIBBLE_W-1:0] a_nib [NIBBLES];
  logic [NIBBLE_W-1:0] b_nib [NIBBLES];
  logic [NIBBLE_W-1:0] a_sel;
  logic [NIBBLE_W-1:0] b_sel;
  logic [NIBBLE_W-1:0] add_sum;
  logic                add_cout;
  logic                idx_last;

  // Split the captured operands into nibble lanes for indexed selection.
  for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_nib
    assign a_nib[gi] = a_reg[gi*NIBBLE_W +: NIBBLE_W];
    assign b_nib[gi] = b_reg[gi*NIBBLE_W +: NIBBLE_W];
  end

  assign idx_last = (idx_reg == IDX_LAST);

  // Pick the operand nibbles addressed by idx (compare-based mux, no wide shifts).
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        a_sel = a_nib[i];
        b_sel = b_nib[i];
      end
    end
  end

  // The single shared nibble adder; carry between nibbles goes only through carry_reg.
  fourbitAdder u_add (
    .a    (a_sel),
    .b    (b_sel),
    .cin  (carry_reg),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Merge this cycle's nibble result into its slot of the sum register.
  always_comb begin
    sum_next = sum_reg;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        sum_next[i*NIBBLE_W +: NIBBLE_W] = add_sum;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: accept in IDLE, step through nibbles in ADD, wait for handshake in DONE.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: if (in_valid)  state_next = ADD;
      ADD:  if (idx_last)  state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one nibble per cycle while adding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
      carry_reg <= 1'b0;
      idx_reg   <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx_reg   <= '0;
          end
        end
        ADD: begin
          sum_reg   <= sum_next;
          carry_reg <= add_cout;
          if (idx_last) begin
            // Index stays on the last nibble rather than wrapping.
            cout_reg <= add_cout;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed corner cases plus
// randomized operations compared against plain integer addition.
module tb_nibble_serial_adder;

  localparam int NIBBLES = 4;
  localparam int W       = 4 * NIBBLES;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          cin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  sum;
  logic          cout;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Runs one operation from IDLE; stalls out_ready for 'hold' cycles in DONE.
  // Returns the cycle number of the accepting edge.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc,
                        input int hold, input string name, output int accept_cyc);
    logic [W:0]   expect_full;
    logic [W-1:0] held_sum;
    logic         held_cout;
    int           lat;
    expect_full = {1'b0, ta} + {1'b0, tb_v} + {{W{1'b0}}, tc};
    check_value({name, ".in_ready_idle"}, in_ready, 1);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    accept_cyc = cyc;
    // Scramble inputs while in flight; in_valid stays high and must be ignored.
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      check_value({name, ".in_ready_add"}, in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check_value({name, ".latency"}, lat, NIBBLES);
    check_value({name, ".sum"}, sum, expect_full[W-1:0]);
    check_value({name, ".cout"}, cout, expect_full[W]);
    held_sum = sum; held_cout = cout;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_value({name, ".hold_valid"}, out_valid, 1);
      check_value({name, ".hold_ready"}, in_ready, 0);
      check_value({name, ".hold_sum"}, {held_cout, held_sum}, {cout, sum});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_value({name, ".released"}, out_valid, 0);
    $display("op %s a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", name, ta, tb_v, tc,
             held_sum, held_cout, lat);
  endtask

  // Time limit so the bench always ends.
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1;
    logic [W-1:0] ra, rb;
    logic         rc;
    int           rh;

    // Reset state while held.
    #12;
    check_value("rst.out_valid", out_valid, 0);
    check_value("rst.busy", busy, 0);
    check_value("rst.sum", sum, 0);
    check_value("rst.cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_value("rst.in_ready", in_ready, 1);

    run_op(16'h1234, 16'h4321, 1'b0, 0, "basic",    t0);
    run_op(16'h0001, 16'hFFFF, 1'b0, 0, "ripple",   t0);
    run_op(16'hFFFF, 16'h0000, 1'b1, 0, "cin_rip",  t0);
    run_op(16'h0000, 16'h0000, 1'b1, 0, "cin_only", t0);
    run_op(16'h8000, 16'h8000, 1'b0, 5, "stall",    t0);

    // Reset in the middle of ADD (idx=2 two cycles after accept).
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_value("midrst.busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check_value("midrst.out_valid", out_valid, 0);
    check_value("midrst.busy", busy, 0);
    check_value("midrst.sum", sum, 0);
    check_value("midrst.cout", cout, 0);
    check_value("midrst.in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check_value("midrst.no_valid", out_valid, 0);
    end
    run_op(16'h00FF, 16'h0001, 1'b0, 0, "after_rst", t0);

    // Back-to-back: accepts must be NIBBLES+2 cycles apart.
    run_op(16'h0F0F, 16'h00F1, 1'b0, 0, "b2b_0", t0);
    run_op(16'h7FFF, 16'h0001, 1'b1, 0, "b2b_1", t1);
    check_value("b2b.spacing", t1 - t0, NIBBLES + 2);

    // Randomized operations with random DONE stalls.
    for (int n = 0; n < 30; n++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      rh = int'($urandom_range(0, 3));
      run_op(ra, rb, rc, rh, "rand", t0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_nibble_serial_adder

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter NIBBLES, default 4: operand width in nibbles; W = 4*NIBBLES.
REQ-002 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand set presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 a  input  W  operand A.
REQ-008 b  input  W  operand B.
REQ-009 cin  input  1  carry into nibble 0.
REQ-010 out_valid  output  1  result held on sum/cout.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 sum  output  W  registered result, (a+b+cin) mod 2^W.
REQ-013 cout  output  1  carry out of the top nibble.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 FSM states SHALL be IDLE, ADD and DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready, capture a, b and cin into registers, clear nibble index idx to 0, load carry register with cin, and go to ADD.
REQ-017 ADD: each cycle, add nibble idx of captured A and B plus the carry register through one 4-bit adder; write the 4-bit result into sum[4*idx+3:4*idx]; load the adder carry-out into the carry register; increment idx.
REQ-018 ADD SHALL exit to DONE on the cycle it processes idx = NIBBLES-1; cout SHALL take that cycle's carry-out.
REQ-019 Latency: out_valid SHALL rise exactly NIBBLES cycles after the accepting clock edge.
REQ-020 DONE: out_valid=1; sum and cout SHALL hold stable until out_valid&out_ready, then go to IDLE.
REQ-021 in_ready SHALL be 0 in ADD and DONE; there is no overlap of accept and deliver. Maximum throughput is one result per NIBBLES+2 cycles.
REQ-022 Input changes on a, b or cin after acceptance SHALL NOT affect the result in flight.
REQ-023 out_valid SHALL NOT drop without a handshake. in_valid asserted outside IDLE is ignored and not queued.
REQ-024 Carry SHALL propagate across nibble boundaries via the carry register only. There is no combinational path from a/b to sum/cout.
REQ-025 idx SHALL be ceil(log2(NIBBLES)) bits wide, or 1 bit when NIBBLES=1. It never wraps beyond NIBBLES-1.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, idx=0, carry=0, sum=0, cout=0, out_valid=0, busy=0. in_ready SHALL be 1 after release.
REQ-027 Reset asserted in ADD or DONE SHALL discard the operation with no output handshake.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 A shared package SHALL hold the state enum typedef (IDLE/ADD/DONE) and the constant NIBBLE_W=4.
REQ-030 The per-nibble add SHALL be one instance of the team's existing four-bit ripple-carry adder, fourbitAdder. Its ports are a[3:0], b[3:0], cin, sum[3:0] and cout.
REQ-031 All remaining logic (FSM, operand and sum registers, idx, carry) SHALL live in nibble_serial_adder.

Verification
REQ-032 a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0; out_valid rises 4 cycles after accept.
REQ-033 a=0x0001, b=0xFFFF, cin=0 -> sum=0x0000, cout=1 (carry crosses all four nibbles).
REQ-034 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Also a=0x0000, b=0x0000, cin=1 -> sum=0x0001, cout=0.
REQ-035 a=0x8000, b=0x8000; hold out_ready=0 for 5 cycles in DONE -> sum=0x0000, cout=1 stable; in_ready=0 throughout.
REQ-036 Pulse rst_n low during ADD with idx=2 -> all outputs reset immediately, no out_valid. The next operation, 0x00FF+0x0001, gives 0x0100 with cout=0.
REQ-037 Two back-to-back operations with out_ready tied 1 -> accepts spaced exactly 6 cycles apart, both results correct.
